// File: rtl/dom_pkg.sv
// Shared helpers for the DOM AND gadget: share-count limits, randomness word
// count and the row-major pair index used to select a z word for share pair (i,j).
package dom_pkg;

   localparam int DOM_D_MIN = 2;
   localparam int DOM_D_MAX = 8;

   function automatic int dom_rnd_words(input int d);
      return d * (d - 1) / 2;
   endfunction

   // i < j is assumed; callers order the pair before asking.
   function automatic int dom_pair_idx(input int i, input int j, input int d);
      return i * d - i * (i + 1) / 2 + (j - i - 1);
   endfunction

   function automatic bit dom_d_legal(input int d);
      return (d >= DOM_D_MIN) && (d <= DOM_D_MAX);
   endfunction

endpackage

// File: rtl/dom_share_reg.sv
// W-bit term register with synchronous active-high reset and load enable; one
// instance per inner/cross term so each domain's state stays separable.
module dom_share_reg #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_en,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/dom_and_nshare.sv
// D-share, W-bit DOM AND gadget with a valid pipeline. Optional output register
// stage enabled by defining DOM_AND_OUTREG_EN (latency 2 instead of 1).
module dom_and_nshare
   import dom_pkg::*;
#(
   parameter int D = 2,
   parameter int W = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [D*W-1:0]                a,
   input  logic [D*W-1:0]                b,
   input  logic [dom_rnd_words(D)*W-1:0] z,
   output logic                          out_valid,
   output logic [D*W-1:0]                c
);

   if (!dom_d_legal(D)) begin : g_bad_d
      $error("dom_and_nshare: D=%0d outside legal range", D);
   end

   // Term matrix: [i][i] is the inner product, [i][j] (i!=j) the resharded cross term.
   logic [W-1:0] w_term_d [D][D];
   logic [W-1:0] w_term_q [D][D];
   logic [D*W-1:0] w_c;
   logic r_v1;

   for (genvar gi = 0; gi < D; gi++) begin : g_row
      for (genvar gj = 0; gj < D; gj++) begin : g_col
         if (gi == gj) begin : g_inner
            assign w_term_d[gi][gj] = a[gi*W +: W] & b[gj*W +: W];
         end else begin : g_cross
            localparam int K = (gi < gj) ? dom_pair_idx(gi, gj, D) : dom_pair_idx(gj, gi, D);
            assign w_term_d[gi][gj] = (a[gi*W +: W] & b[gj*W +: W]) ^ z[K*W +: W];
         end
         dom_share_reg #(.W(W)) u_term (
            .clk  (clk),
            .rst  (rst),
            .i_en (in_valid),
            .i_d  (w_term_d[gi][gj]),
            .o_q  (w_term_q[gi][gj])
         );
      end
   end

   // Compression reads registered terms only, so no input glitch reaches it.
   always_comb begin
      w_c = '0;
      for (int i = 0; i < D; i++) begin
         for (int j = 0; j < D; j++) begin
            w_c[i*W +: W] = w_c[i*W +: W] ^ w_term_q[i][j];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1 <= 1'b0;
      end else begin
         r_v1 <= in_valid;
      end
   end

`ifdef DOM_AND_OUTREG_EN
   logic [D*W-1:0] w_c_q;
   logic r_v2;

   dom_share_reg #(.W(D*W)) u_c_out (
      .clk  (clk),
      .rst  (rst),
      .i_en (r_v1),
      .i_d  (w_c),
      .o_q  (w_c_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v2 <= 1'b0;
      end else begin
         r_v2 <= r_v1;
      end
   end

   assign c         = w_c_q;
   assign out_valid = r_v2;
`else
   assign c         = w_c;
   assign out_valid = r_v1;
`endif

endmodule
